vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Upstream stage of the game pixel generator. Generates 640x480@60 VGA raster timing from the system clock.
//   Drives h_cnt/v_cnt into the pixel generator and drives hsync/vsync/valid to the top-level VGA pins.
//   The pixel generator reads synchronous ROM/BRAM. Sync and valid are therefore delayed so they line up with its pixel output.
// PARAMETERS
//   CLK_DIV   4    system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal >= 1
//   H_VIS     640  visible pixels per line
//   H_FP      16   horizontal front porch (pixels)
//   H_SYNC    96   hsync pulse width (pixels)
//   H_BP      48   horizontal back porch (pixels)
//   V_VIS     480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vsync pulse width (lines)
//   V_BP      33   vertical back porch (lines)
//   PIPE_DLY  1    pixel periods of delay applied to hsync/vsync/valid; legal 1..4
// PORTS
//   clk          in   1   system clock, 100 MHz
//   rst_n        in   1   asynchronous active-low reset
//   pclk_en      out  1   one-clk pulse, once every CLK_DIV clks; marks a pixel tick
//   h_cnt        out  10  current column, 0..H_TOTAL-1 (H_TOTAL=800)
//   v_cnt        out  10  current line, 0..V_TOTAL-1 (V_TOTAL=525)
//   valid        out  1   visible-area flag (delayed per CONFIGURATION)
//   hsync        out  1   horizontal sync, active low (delayed)
//   vsync        out  1   vertical sync, active low (delayed)
//   frame_start  out  1   one-clk pulse on the pixel tick where the counters wrap to (0,0)
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     div counter=0, pclk_en=0, h_cnt=0, v_cnt=0, valid=0, hsync=1, vsync=1, frame_start=0.
//     All delay-pipe stages load their inactive values (valid 0, syncs 1).
//   - Divider: counts 0..CLK_DIV-1 and wraps. pclk_en=1 only in the clk where div==CLK_DIV-1.
//     The first pulse occurs CLK_DIV clks after reset release. CLK_DIV==1 gives pclk_en tied 1 after reset.
//   - Counters: advance only on the clk where pclk_en=1.
//     h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
//     v_cnt at V_TOTAL-1 together with an h wrap returns to 0. No other wrap states.
//   - Raw decode, combinational from the counters:
//     vis = (h_cnt<H_VIS)&&(v_cnt<V_VIS)
//     hs  = !(h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]), i.e. low for 656..751
//     vs  = !(v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]), i.e. low for 490..491
//   - Delay pipe: PIPE_DLY registers for vis/hs/vs, shifted only on pclk_en.
//     Outputs are stage PIPE_DLY, so output at tick N reflects counters at tick N-PIPE_DLY.
//     This covers the pixel generator's 1-cycle BRAM read latency.
//   - h_cnt/v_cnt are registered and never delayed. Downstream address logic uses them directly.
//   - frame_start: registered; high for exactly one clk, in the clk after the tick that
//     moves (799,524)->(0,0). Not delayed by the pipe.
//   - Reset mid-frame: all state returns immediately to reset values.
//     The first post-reset frame is full length with no partial sync pulse.
//   - All widths are 10-bit unsigned. Compare constants are computed from parameters at elaboration.
//   - No overflow is possible (H_TOTAL, V_TOTAL < 1024); parameter sets exceeding 1023 are illegal.
// CONFIGURATION
//   VGA_PIPE_ALIGN_EN defined:
//     delay pipe present; valid/hsync/vsync lag the counters by PIPE_DLY ticks.
//   VGA_PIPE_ALIGN_EN undefined:
//     pipe removed; valid/hsync/vsync are registered copies of vis/hs/vs updated on the
//     same pclk_en as the counters (0 ticks of lag). PIPE_DLY is ignored.
//   Counter, divider and frame_start behaviour are identical in both builds.
// TESTING
//   1. Hold rst_n=0 for 10 clks, release:
//      outputs are at reset values; first pclk_en is at clk 4 after release; h_cnt=1 on the following clk.
//   2. Run one line with default params:
//      exactly 800 pclk_en between h wraps; hsync low for 96 ticks starting 1 tick after h_cnt=656 (ALIGN_EN).
//   3. Run one full frame:
//      420000 pclk_en per frame (800*525); vsync low for 1600 ticks;
//      valid high for 307200 ticks; frame_start pulses exactly once.
//   4. Wrap check at (799,524):
//      next tick gives h_cnt=0, v_cnt=0; frame_start=1 for one clk; valid rises 1 tick later (ALIGN_EN, PIPE_DLY=1).
//   5. Assert rst_n at h_cnt=700, v_cnt=300 for 3 clks:
//      immediate return to reset values; counting restarts from (0,0); no hsync glitch.
//   6. Build without VGA_PIPE_ALIGN_EN:
//      hsync falls on the same tick h_cnt becomes 656; valid falls on the tick h_cnt becomes 640.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel generator and the VGA pins.
// The master drives every signal and the slave observes them.
interface vga_timing_gen_if;
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    modport master (
        output pclk_en,
        output h_cnt,
        output v_cnt,
        output valid,
        output hsync,
        output vsync,
        output frame_start
    );

    modport slave (
        input pclk_en,
        input h_cnt,
        input v_cnt,
        input valid,
        input hsync,
        input vsync,
        input frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate divider, h/v counters, sync/valid decode and frame pulse.
// Build option VGA_PIPE_ALIGN_EN delays valid/hsync/vsync by PIPE_DLY ticks; otherwise they have no lag.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    // Sync bundle packing is {vis, hs, vs}; idle means blanked with both syncs deasserted.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DLY < 1 || PIPE_DLY > 4)
    begin : g_param_check
        $error("vga_timing_gen: illegal parameter set");
    end

    function automatic logic [2:0] sync_decode(input logic [9:0] h, input logic [9:0] v);
        logic vis;
        logic hs;
        logic vs;
        vis = (h < H_VIS_C) && (v < V_VIS_C);
        hs  = !((h >= HS_FIRST) && (h <= HS_LAST));
        vs  = !((v >= VS_FIRST) && (v <= VS_LAST));
        return {vis, hs, vs};
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic             pclk_en_q, pclk_en_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             fs_q, fs_d;
    logic             h_wrap, v_wrap;
    logic [2:0]       sync_out;

    // Divider: pclk_en is registered so it stays low through reset even when CLK_DIV is 1.
    always_comb begin
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pclk_en_d = (div_d == DIV_LAST);
    end

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (pclk_en_q) begin
            h_d = h_wrap ? '0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 10'd1;
            end
        end
        fs_d = pclk_en_q && h_wrap && v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            pclk_en_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            fs_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            pclk_en_q <= pclk_en_d;
            h_q       <= h_d;
            v_q       <= v_d;
            fs_q      <= fs_d;
        end
    end

`ifdef VGA_PIPE_ALIGN_EN
    // Stage 0 captures the decode of the counters before they step, giving one tick of lag per stage.
    logic [2:0] pipe_q [PIPE_DLY];
    logic [2:0] pipe_d [PIPE_DLY];

    always_comb begin
        pipe_d[0] = sync_decode(h_q, v_q);
        for (int i = 1; i < int'(PIPE_DLY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PIPE_DLY); i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
        end else if (pclk_en_q) begin
            pipe_q <= pipe_d;
        end
    end

    assign sync_out = pipe_q[PIPE_DLY-1];
`else
    // Decoding the next counter values keeps the syncs in step with the counters on the same tick.
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = sync_decode(h_d, v_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= SYNC_IDLE;
        end else if (pclk_en_q) begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;
`endif

    assign vga.pclk_en     = pclk_en_q;
    assign vga.h_cnt       = h_q;
    assign vga.v_cnt       = v_q;
    assign vga.valid       = sync_out[2];
    assign vga.hsync       = sync_out[1];
    assign vga.vsync       = sync_out[0];
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen using a shrunken raster so several frames fit in a short run.
// Expected outputs come from the clock count since reset release via tick/position arithmetic.
module tb_vga_timing_gen;

    localparam int D     = 3;
    localparam int HV    = 8;
    localparam int HF    = 2;
    localparam int HS    = 3;
    localparam int HB    = 2;
    localparam int VV    = 4;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int P_DLY = 2;
    localparam int HT    = HV + HF + HS + HB;
    localparam int VT    = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef VGA_PIPE_ALIGN_EN
    localparam int LAG = P_DLY;
`else
    localparam int LAG = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_timing_gen_if vif ();

    vga_timing_gen #(
        .CLK_DIV (D),
        .H_VIS   (HV),
        .H_FP    (HF),
        .H_SYNC  (HS),
        .H_BP    (HB),
        .V_VIS   (VV),
        .V_FP    (VF),
        .V_SYNC  (VS),
        .V_BP    (VB),
        .PIPE_DLY(P_DLY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vga  (vif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int c     = 0;   // rising edges seen since the last reset release

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (clk %0d after release)", tag, obs, exp, c);
        end
    endtask

    task automatic check_all();
        int t;
        int p;
        int e_pclk;
        int e_fs;
        int e_vis;
        int e_hs;
        int e_vs;
        int ph;
        int pv;
        t      = c / D;
        e_pclk = (c > 0 && (c % D) == D - 1) ? 1 : 0;
        e_fs   = (c > 0 && (c % D) == 0 && (t % FRAME) == 0) ? 1 : 0;
        e_vis  = 0;
        e_hs   = 1;
        e_vs   = 1;
        if (t >= ((LAG > 0) ? LAG : 1)) begin
            p     = t - LAG;
            ph    = p % HT;
            pv    = (p / HT) % VT;
            e_vis = (ph < HV && pv < VV) ? 1 : 0;
            e_hs  = (ph >= HV + HF && ph < HV + HF + HS) ? 0 : 1;
            e_vs  = (pv >= VV + VF && pv < VV + VF + VS) ? 0 : 1;
        end
        check_eq("pclk_en",     int'(vif.pclk_en),     e_pclk);
        check_eq("h_cnt",       int'(vif.h_cnt),       t % HT);
        check_eq("v_cnt",       int'(vif.v_cnt),       (t / HT) % VT);
        check_eq("valid",       int'(vif.valid),       e_vis);
        check_eq("hsync",       int'(vif.hsync),       e_hs);
        check_eq("vsync",       int'(vif.vsync),       e_vs);
        check_eq("frame_start", int'(vif.frame_start), e_fs);
    endtask

    task automatic run_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        c     = 0;
        repeat (10) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        for (int run = 0; run < 6; run++) begin
            n = (run == 0) ? 2 * FRAME * D + 20 : int'($urandom_range(40, 2 * FRAME * D));
            run_clks(n);
            // Asynchronous reset landing between clock edges, held for a few cycles.
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1;
            c = 0;
            check_all();
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                check_all();
            end
            rst_n = 1'b1;
        end
        run_clks(FRAME * D + 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
